// File: rtl/word_loader_if.sv
// Bundles the word loader's stream, SRAM write, matcher and token signals.
// slave is the word_loader side; master is the surrounding environment.
interface word_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  match_clr;
    logic                  match_cs;
    logic                  match_done;
    logic                  match_found;
    logic                  tok_valid;
    logic                  tok_ready;
    logic                  tok_found;
    logic [ADDR_WIDTH-1:0] tok_len;
    logic                  tok_ovf;
    logic                  tok_timeout;

    modport slave (
        input  in_valid, in_data, in_last, match_done, match_found, tok_ready,
        output in_ready, wr_en, wr_addr, wr_data, match_clr, match_cs,
        output tok_valid, tok_found, tok_len, tok_ovf, tok_timeout
    );

    modport master (
        output in_valid, in_data, in_last, match_done, match_found, tok_ready,
        input  in_ready, wr_en, wr_addr, wr_data, match_clr, match_cs,
        input  tok_valid, tok_found, tok_len, tok_ovf, tok_timeout
    );
endinterface

// File: rtl/word_loader.sv
// Splits a character stream into NUL-terminated words in the word SRAM, runs the
// matcher per word and emits one token each. Optional watchdog: MATCH_TIMEOUT_EN.
module word_loader #(
    parameter int                     ADDR_WIDTH     = 4,
    parameter int                     DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0]  DELIM          = 8'h20,
    parameter int                     TIMEOUT_CYCLES = 64
) (
    input logic          clk,
    input logic          rst,
    word_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] MAX_LEN = '1;

    typedef enum logic [2:0] {
        S_COLLECT, S_DRAIN, S_TERM, S_CLEAR, S_LAUNCH, S_WAIT, S_EMIT
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_len;
    logic                  r_ovf, r_found, r_timeout, r_last_pend;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  w_in_ready, w_accept, w_is_delim, w_full, w_tmo, w_term, w_emit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign w_is_delim = (bus.in_data == DELIM) || (bus.in_data == '0);
    // A flushed last char holds off input for one cycle while its write lands.
    assign w_in_ready = ((r_state == S_COLLECT) && !r_last_pend) || (r_state == S_DRAIN);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_full     = (r_len == MAX_LEN);
    assign w_term     = (r_state == S_TERM);
    assign w_emit     = (r_state == S_EMIT);

`ifdef MATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT)) r_tmo_cnt <= '0;
        else                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_tmo = (r_state == S_WAIT) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: begin
                if (r_last_pend) begin
                    w_state_nxt = S_TERM;
                end else if (w_accept) begin
                    if (w_is_delim) begin
                        if (r_len != '0) w_state_nxt = S_TERM;
                    end else if (w_full) begin
                        w_state_nxt = bus.in_last ? S_EMIT : S_DRAIN;
                    end
                end
            end
            S_DRAIN:  if (w_accept && (w_is_delim || bus.in_last)) w_state_nxt = S_EMIT;
            S_TERM:   w_state_nxt = S_CLEAR;
            S_CLEAR:  w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT:   if (bus.match_done || w_tmo) w_state_nxt = S_EMIT;
            S_EMIT:   if (bus.tok_ready) w_state_nxt = S_COLLECT;
            default:  w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_found     <= 1'b0;
            r_timeout   <= 1'b0;
            r_last_pend <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (r_last_pend) begin
                        r_last_pend <= 1'b0;
                    end else if (w_accept && !w_is_delim) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_wr_en     <= 1'b1;
                            r_wr_addr   <= r_len;
                            r_wr_data   <= bus.in_data;
                            r_len       <= r_len + 1'b1;
                            r_last_pend <= bus.in_last;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.match_done) r_found   <= bus.match_found;
                    else if (w_tmo)     r_timeout <= 1'b1;
                end
                S_EMIT: begin
                    if (bus.tok_ready) begin
                        r_len     <= '0;
                        r_ovf     <= 1'b0;
                        r_found   <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Character writes are registered; the NUL write is driven directly in TERM.
    assign bus.in_ready    = w_in_ready;
    assign bus.wr_en       = r_wr_en || w_term;
    assign bus.wr_addr     = w_term ? r_len : r_wr_addr;
    assign bus.wr_data     = w_term ? '0 : r_wr_data;
    assign bus.match_clr   = (r_state == S_CLEAR);
    assign bus.match_cs    = (r_state == S_LAUNCH);
    assign bus.tok_valid   = w_emit;
    assign bus.tok_found   = w_emit && r_found;
    assign bus.tok_len     = w_emit ? r_len : '0;
    assign bus.tok_ovf     = w_emit && r_ovf;
    assign bus.tok_timeout = w_emit && r_timeout;
endmodule

// File: tb/tb_word_loader.sv
// Directed bench for word_loader: per-word vector table plus stall, reset-in-WAIT
// and (with MATCH_TIMEOUT_EN) watchdog sequences.
module tb_word_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    word_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    word_loader dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        string chars;
        bit    last;
        bit    nul;
        bit    mfound;
        bit    exp_found;
        int    exp_len;
        bit    exp_ovf;
        int    exp_wr;
        int    exp_cs;
        string word;
    } vec_t;

    typedef struct { bit found; int len; bit ovf; bit tmo; } tok_t;

    int   total = 0;
    int   bad   = 0;
    int   wr_cnt = 0, cs_cnt = 0, clr_cnt = 0, ovl_cnt = 0;
    logic [7:0] mem [16];
    tok_t tokq[$];

    // Matcher model: done/found three cycles after cs, cleared by clr.
    bit       m_en = 1'b1;
    bit       m_found_cfg = 1'b0;
    int       m_cnt = 0;
    always @(posedge clk) begin
        if (rst || bus.match_clr) begin
            bus.match_done  <= 1'b0;
            bus.match_found <= 1'b0;
            m_cnt           <= 0;
        end else if (bus.match_cs) begin
            m_cnt <= 3;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && m_en) begin
                bus.match_done  <= 1'b1;
                bus.match_found <= m_found_cfg;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] = bus.wr_data;
            wr_cnt++;
        end
        if (bus.match_cs) cs_cnt++;
        if (bus.match_clr) clr_cnt++;
        if (bus.wr_en && bus.match_cs) ovl_cnt++;
        if (bus.tok_valid && bus.tok_ready)
            tokq.push_back('{bus.tok_found, int'(bus.tok_len), bus.tok_ovf, bus.tok_timeout});
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the char is accepted.
    task automatic send(input logic [7:0] c, input bit l);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        bus.in_last  = l;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("send_ready_wait", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_cs(input string name);
        int n = 0;
        while (!bus.match_cs && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(name, 0, 1);
    endtask

    function automatic vec_t mk(string c, bit l, bit nl, bit mf, bit ef, int el, bit eo,
                                int ew, int ec, string w);
        vec_t v;
        v.chars = c; v.last = l; v.nul = nl; v.mfound = mf; v.exp_found = ef;
        v.exp_len = el; v.exp_ovf = eo; v.exp_wr = ew; v.exp_cs = ec; v.word = w;
        return v;
    endfunction

    vec_t vecs[9];

    initial begin
        string x17;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.tok_ready = 1'b1;

        x17 = "";
        for (int i = 0; i < 17; i++) x17 = {x17, "x"};
        vecs[0] = mk("cat ",             0, 0, 1, 1,  3, 0,  4, 1, "cat");
        vecs[1] = mk("  ab",             1, 0, 0, 0,  2, 0,  3, 1, "ab");
        vecs[2] = mk({x17, " "},         0, 0, 1, 0, 15, 1, 15, 0, "");
        vecs[3] = mk("go ",              0, 0, 1, 1,  2, 0,  3, 1, "go");
        vecs[4] = mk("hello",            0, 1, 0, 0,  5, 0,  6, 1, "hello");
        vecs[5] = mk("abcdefghijklmno ", 0, 0, 1, 1, 15, 0, 16, 1, "abcdefghijklmno");
        vecs[6] = mk("abcdefghijklmnop", 1, 0, 1, 0, 15, 1, 15, 0, "");
        vecs[7] = mk("z",                1, 0, 1, 1,  1, 0,  2, 1, "z");
        vecs[8] = mk(" q  ",             0, 0, 0, 0,  1, 0,  2, 1, "q");

        repeat (3) @(negedge clk);
        check("rst_in_ready",  int'(bus.in_ready), 1);
        check("rst_wr_en",     int'(bus.wr_en), 0);
        check("rst_tok_valid", int'(bus.tok_valid), 0);
        check("rst_clr_cs",    int'(bus.match_clr | bus.match_cs), 0);
        check("rst_tok_flds",  int'({bus.tok_found, bus.tok_len, bus.tok_ovf, bus.tok_timeout}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            int   wr0, cs0, clr0, n;
            bit   ok;
            tok_t t;
            wr0 = wr_cnt; cs0 = cs_cnt; clr0 = clr_cnt;
            m_found_cfg = vecs[v].mfound;
            for (int i = 0; i < vecs[v].chars.len(); i++)
                send(vecs[v].chars[i], vecs[v].last && (i == vecs[v].chars.len() - 1));
            if (vecs[v].nul) send(8'h00, 1'b0);
            n = 0;
            while (tokq.size() == 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d_tok_seen", v), int'(tokq.size() != 0), 1);
            if (tokq.size() != 0) begin
                t = tokq.pop_front();
                check($sformatf("v%0d_found", v), int'(t.found), int'(vecs[v].exp_found));
                check($sformatf("v%0d_len", v),   t.len,          vecs[v].exp_len);
                check($sformatf("v%0d_ovf", v),   int'(t.ovf),    int'(vecs[v].exp_ovf));
                check($sformatf("v%0d_tmo", v),   int'(t.tmo),    0);
            end
            check($sformatf("v%0d_writes", v), wr_cnt - wr0, vecs[v].exp_wr);
            check($sformatf("v%0d_cs", v),     cs_cnt - cs0, vecs[v].exp_cs);
            check($sformatf("v%0d_clr", v),    clr_cnt - clr0, vecs[v].exp_cs);
            if (!vecs[v].exp_ovf) begin
                ok = 1'b1;
                for (int i = 0; i < vecs[v].word.len(); i++)
                    if (mem[i] != vecs[v].word[i]) ok = 1'b0;
                if (mem[vecs[v].word.len()] != 8'h00) ok = 1'b0;
                check($sformatf("v%0d_mem", v), int'(ok), 1);
            end
        end
        check("wr_cs_overlap", ovl_cnt, 0);

        // EMIT back-pressure: token held stable, input stalled.
        begin
            int n = 0;
            bus.tok_ready = 1'b0;
            m_found_cfg   = 1'b1;
            send("d", 1'b0); send("o", 1'b0); send("g", 1'b0); send(" ", 1'b0);
            while (!bus.tok_valid && n < 300) begin
                @(negedge clk);
                n++;
            end
            for (int c = 0; c < 5; c++) begin
                check("stall_valid",    int'(bus.tok_valid), 1);
                check("stall_found",    int'(bus.tok_found), 1);
                check("stall_len",      int'(bus.tok_len), 3);
                check("stall_in_ready", int'(bus.in_ready), 0);
                @(negedge clk);
            end
            #1 bus.tok_ready = 1'b1;
            @(negedge clk);
            check("stall_release_valid", int'(bus.tok_valid), 0);
            check("stall_release_ready", int'(bus.in_ready), 1);
            tokq.delete();
        end

        // Reset while waiting on the matcher aborts the word.
        begin
            m_en = 1'b0;
            send("h", 1'b0); send("i", 1'b0); send(" ", 1'b0);
            wait_cs("rstwait_cs_wait");
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("rstwait_in_ready", int'(bus.in_ready), 1);
            check("rstwait_outs", int'({bus.wr_en, bus.match_clr, bus.match_cs, bus.tok_valid,
                                        bus.tok_found, bus.tok_len, bus.tok_ovf, bus.tok_timeout}), 0);
            rst = 1'b0;
            repeat (80) @(negedge clk);
            check("rstwait_no_token", tokq.size(), 0);
            m_en = 1'b1;
        end

`ifdef MATCH_TIMEOUT_EN
        // Matcher never answers: watchdog fires after 64 WAIT cycles.
        begin
            int   k = 0;
            tok_t t;
            m_en = 1'b0;
            send("t", 1'b0); send("o", 1'b0); send(" ", 1'b0);
            wait_cs("tmo_cs_wait");
            while (!bus.tok_valid && k < 300) begin
                @(negedge clk);
                k++;
            end
            check("tmo_latency", k, 65);
            repeat (2) @(negedge clk);
            check("tmo_tok_seen", tokq.size(), 1);
            if (tokq.size() != 0) begin
                t = tokq.pop_front();
                check("tmo_flag",  int'(t.tmo), 1);
                check("tmo_found", int'(t.found), 0);
                check("tmo_len",   t.len, 2);
            end
            m_en = 1'b1;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/word_loader.md
Name: word_loader

Overview:
- Upstream stage of the vocabulary matcher.
- Accepts a character stream over valid/ready and splits it into words on a delimiter.
- Writes each word, NUL-terminated, into the word SRAM from address 0.
- Clears and starts the matcher, waits for its done/found result, then emits one token record per word downstream.

Parameters:
ADDR_WIDTH, 4, word SRAM address width; max word length = 2^ADDR_WIDTH-1 chars
DATA_WIDTH, 8, character width
DELIM, 8'h20, delimiter character (space)
TIMEOUT_CYCLES, 64, matcher watchdog limit (used only with MATCH_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  character valid
in_data  in  DATA_WIDTH  character
in_last  in  1  last character of stream, qualified by in_valid
in_ready  out  1  character accepted when in_valid&&in_ready
wr_en  out  1  word SRAM write strobe
wr_addr  out  ADDR_WIDTH  word SRAM write address
wr_data  out  DATA_WIDTH  word SRAM write data
match_clr  out  1  one-cycle matcher clear pulse
match_cs  out  1  one-cycle matcher start pulse
match_done  in  1  matcher done (sticky until cleared)
match_found  in  1  matcher found, valid with match_done
tok_valid  out  1  token record valid
tok_ready  in  1  token record accepted
tok_found  out  1  word is in vocabulary
tok_len  out  ADDR_WIDTH  word length in chars, excluding NUL
tok_ovf  out  1  word exceeded max length; not matched
tok_timeout  out  1  matcher watchdog expired (0 when macro absent)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; state COLLECT; length counter 0.
- Character classes: DELIM and 8'h00 are both delimiters.
- States: COLLECT, DRAIN, TERM, CLEAR, LAUNCH, WAIT, EMIT.
- in_ready = 1 only in COLLECT and DRAIN.
- COLLECT, non-delimiter accepted:
  - wr_en=1 next cycle with wr_addr=len, wr_data=char; len++.
  - If len was already 2^ADDR_WIDTH-1: no write, set ovf, go to DRAIN.
- COLLECT, delimiter accepted:
  - len==0: stay in COLLECT; no write, no launch. Empty words are dropped.
  - len>0: go to TERM.
- in_last with a non-delimiter char: write the char, then go to TERM (word flushed). If that char overflows: EMIT with ovf.
- DRAIN: discard chars without writing until a delimiter or in_last is accepted, then go to EMIT with tok_found=0, tok_ovf=1, tok_len=2^ADDR_WIDTH-1. The matcher is not started.
- TERM: wr_en=1, wr_addr=len, wr_data=0 for one cycle, then CLEAR.
- CLEAR: match_clr=1 for one cycle, then LAUNCH.
- LAUNCH: match_cs=1 for one cycle, then WAIT.
- WAIT: on match_done=1, latch match_found into tok_found, then EMIT. match_done seen in CLEAR or LAUNCH is ignored.
- EMIT: tok_valid held with stable fields until tok_ready; the cycle after the handshake, len=0, ovf=0, state COLLECT.
- Latency, delimiter accept to match_cs: 3 cycles (TERM, CLEAR, LAUNCH).
- tok_ready=1 while tok_valid=0 has no effect.
- Reset in any state aborts the word: no token emitted, SRAM contents don't care.
- wr_en never asserts outside COLLECT-write and TERM; match_cs never coincides with wr_en.

Optional Feature:
MATCH_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If match_done is not seen within TIMEOUT_CYCLES cycles, go to EMIT with tok_found=0, tok_timeout=1.
  - A late match_done after the timeout is ignored; the next word's CLEAR resets the matcher.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - tok_timeout tied to 0.

Test Plan:
- Stream "cat " with matcher returning found=1 three cycles after cs -> writes 'c','a','t',0 at addresses 0..3; one match_clr then one match_cs; token found=1, len=3, ovf=0.
- Stream "  ab" with in_last on 'b', found=0 -> leading delimiters produce no activity; writes 'a','b',0; token found=0, len=2.
- 17-char word then space, ADDR_WIDTH=4 -> exactly 15 writes, no match_cs, token ovf=1, len=15, found=0; next word processes normally.
- tok_ready held 0 for 5 cycles during EMIT -> tok_valid and fields stable, in_ready=0; on tok_ready=1, COLLECT the next cycle.
- rst asserted in WAIT -> next cycle all outputs 0, in_ready=1, no token emitted.
- MATCH_TIMEOUT_EN, TIMEOUT_CYCLES=64, match_done never asserted -> token with timeout=1, found=0 after 64 WAIT cycles.
